// File: rtl/cutecar_pio_pkg.sv
// Shared definitions for the car level/indicator output PIO with PWM.
package cutecar_pio_pkg;

  localparam int AV_ADDR_W = 4;
  localparam int AV_DATA_W = 32;

  typedef logic [AV_ADDR_W-1:0] av_addr_t;
  typedef logic [AV_DATA_W-1:0] av_data_t;

  // Word addresses of the register map
  localparam av_addr_t ADDR_DATA     = 4'd0;
  localparam av_addr_t ADDR_MODE     = 4'd1;
  localparam av_addr_t ADDR_OUTSET   = 4'd2;
  localparam av_addr_t ADDR_OUTCLEAR = 4'd3;
  localparam av_addr_t ADDR_PRESCALE = 4'd4;
  localparam av_addr_t ADDR_PERIOD   = 4'd5;
  localparam av_addr_t ADDR_CONTROL  = 4'd6;
  localparam av_addr_t ADDR_COUNTER  = 4'd7;
  localparam av_addr_t ADDR_DUTY0    = 4'd8;

  // CONTROL register bit positions
  localparam int EN_BIT = 0;

  // One decoded bus write
  typedef struct packed {
    logic     we;
    av_addr_t addr;
    av_data_t data;
  } av_wr_t;

  // Address of the duty shadow register for channel ch
  function automatic av_addr_t duty_addr(input int ch);
    return av_addr_t'(int'(ADDR_DUTY0) + ch);
  endfunction

endpackage

// File: rtl/cutecar_level_pwm_if.sv
// Avalon-MM slave bus bundle for the level PWM block (zero wait states).
interface cutecar_level_pwm_if;
  import cutecar_pio_pkg::*;

  av_addr_t address;
  logic     chipselect;
  logic     write_n;
  av_data_t writedata;
  av_data_t readdata;

  modport master (
    output address, chipselect, write_n, writedata,
    input  readdata
  );

  modport slave (
    input  address, chipselect, write_n, writedata,
    output readdata
  );

endinterface

// File: rtl/cutecar_pwm_timebase.sv
// Shared PWM timebase: prescaler, period counter and the period
// shadow/active pair. Active period reloads only at the wrap.
module cutecar_pwm_timebase #(
  parameter int CNT_W = 8,
  parameter int PRE_W = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             i_en,
  input  logic [PRE_W-1:0] i_prescale,
  input  logic             i_period_we,
  input  logic [CNT_W-1:0] i_period_wdata,
  output logic             o_tick,
  output logic             o_wrap,
  output logic [CNT_W-1:0] o_cnt,
  output logic [CNT_W-1:0] o_period_sh
);

  logic [PRE_W-1:0] r_pre_cnt;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] r_period_sh;
  logic [CNT_W-1:0] r_period_act;
  logic             w_tick;
  logic             w_wrap;

  // >= rather than == so that lowering PRESCALE below the running count
  // ends the current prescale interval instead of rolling through 2^PRE_W.
  assign w_tick = i_en && (r_pre_cnt >= i_prescale);
  assign w_wrap = w_tick && (r_cnt == r_period_act);

  // Prescaler: counts 0..PRESCALE while enabled, parked at 0 otherwise
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)               r_pre_cnt <= '0;
    else if (!i_en || w_tick)   r_pre_cnt <= '0;
    else                        r_pre_cnt <= r_pre_cnt + PRE_W'(1);
  end

  // Period counter: one step per tick, back to 0 after period_act
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)      r_cnt <= '0;
    else if (!i_en)    r_cnt <= '0;
    else if (w_wrap)   r_cnt <= '0;
    else if (w_tick)   r_cnt <= r_cnt + CNT_W'(1);
  end

  // Period shadow written from the bus
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)         r_period_sh <= '0;
    else if (i_period_we) r_period_sh <= i_period_wdata;
  end

  // Active period: tracks the shadow while idle; when running it reloads
  // at the wrap from the pre-write shadow, so a same-cycle write waits a period
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)              r_period_act <= '0;
    else if (!i_en || w_wrap)  r_period_act <= r_period_sh;
  end

  assign o_tick      = w_tick;
  assign o_wrap      = w_wrap;
  assign o_cnt       = r_cnt;
  assign o_period_sh = r_period_sh;

endmodule

// File: rtl/cutecar_level_pwm.sv
// Level/indicator output PIO: legacy DATA register with atomic set/clear,
// plus per-channel PWM mode driven from a shared timebase.
module cutecar_level_pwm
  import cutecar_pio_pkg::*;
#(
  parameter int N_CH  = 7,
  parameter int CNT_W = 8,
  parameter int PRE_W = 16
) (
  input  logic                clk,
  input  logic                reset_n,
  cutecar_level_pwm_if.slave  bus,
  output logic [N_CH-1:0]     out_port
);

  av_wr_t                      w_wr;
  logic [N_CH-1:0]             w_wch;
  logic [N_CH-1:0]             r_data;
  logic [N_CH-1:0]             r_mode;
  logic [N_CH-1:0]             r_pwm_q;
  logic [PRE_W-1:0]            r_prescale;
  logic                        r_en;
  logic [N_CH-1:0][CNT_W-1:0]  r_duty_sh;
  logic [N_CH-1:0][CNT_W-1:0]  r_duty_act;
  logic                        w_tick;
  logic                        w_wrap;
  logic [CNT_W-1:0]            w_cnt;
  logic [CNT_W-1:0]            w_period_sh;
  logic                        w_unused;

  // Capture the bus write of this cycle
  always_comb begin
    w_wr.we   = bus.chipselect && !bus.write_n;
    w_wr.addr = bus.address;
    w_wr.data = bus.writedata;
  end

  assign w_wch = w_wr.data[N_CH-1:0];

  // Tick is only needed inside the timebase; upper write bits are don't-care
  assign w_unused = ^{w_tick, w_wr.data};

  cutecar_pwm_timebase #(
    .CNT_W (CNT_W),
    .PRE_W (PRE_W)
  ) u_tb (
    .clk            (clk),
    .reset_n        (reset_n),
    .i_en           (r_en),
    .i_prescale     (r_prescale),
    .i_period_we    (w_wr.we && (w_wr.addr == ADDR_PERIOD)),
    .i_period_wdata (w_wr.data[CNT_W-1:0]),
    .o_tick         (w_tick),
    .o_wrap         (w_wrap),
    .o_cnt          (w_cnt),
    .o_period_sh    (w_period_sh)
  );

  // DATA: direct write plus atomic set/clear views of the same bits
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_data <= '0;
    else if (w_wr.we) begin
      case (w_wr.addr)
        ADDR_DATA:     r_data <= w_wch;
        ADDR_OUTSET:   r_data <= r_data | w_wch;
        ADDR_OUTCLEAR: r_data <= r_data & ~w_wch;
        default:       r_data <= r_data;
      endcase
    end
  end

  // MODE, PRESCALE and CONTROL configuration registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_mode     <= '0;
      r_prescale <= '0;
      r_en       <= 1'b0;
    end else if (w_wr.we) begin
      if (w_wr.addr == ADDR_MODE)     r_mode     <= w_wch;
      if (w_wr.addr == ADDR_PRESCALE) r_prescale <= w_wr.data[PRE_W-1:0];
      if (w_wr.addr == ADDR_CONTROL)  r_en       <= w_wr.data[EN_BIT];
    end
  end

  // Duty shadows, one word per channel starting at DUTY0
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_duty_sh <= '0;
    else begin
      for (int i = 0; i < N_CH; i++)
        if (w_wr.we && (w_wr.addr == duty_addr(i)))
          r_duty_sh[i] <= w_wr.data[CNT_W-1:0];
    end
  end

  // Active duty: follow shadows while idle, reload only at the period
  // boundary while running so a pulse is never cut or stretched mid-period
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)             r_duty_act <= '0;
    else if (!r_en || w_wrap) r_duty_act <= r_duty_sh;
  end

  // Registered comparators; duty 0 stays low, duty > period stays high
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_pwm_q <= '0;
    else begin
      for (int i = 0; i < N_CH; i++)
        r_pwm_q[i] <= r_en && (w_cnt < r_duty_act[i]);
    end
  end

  // Output mux: MODE picks PWM, otherwise the level from DATA
  assign out_port = (r_mode & r_pwm_q) | (~r_mode & r_data);

  // Combinational zero-wait readback, zero-extended; holes read as 0
  always_comb begin
    bus.readdata = '0;
    case (bus.address)
      ADDR_DATA:     bus.readdata[N_CH-1:0]  = r_data;
      ADDR_MODE:     bus.readdata[N_CH-1:0]  = r_mode;
      ADDR_PRESCALE: bus.readdata[PRE_W-1:0] = r_prescale;
      ADDR_PERIOD:   bus.readdata[CNT_W-1:0] = w_period_sh;
      ADDR_CONTROL:  bus.readdata[EN_BIT]    = r_en;
      ADDR_COUNTER:  bus.readdata[CNT_W-1:0] = w_cnt;
      default: begin
        for (int i = 0; i < N_CH; i++)
          if (bus.address == duty_addr(i))
            bus.readdata[CNT_W-1:0] = r_duty_sh[i];
      end
    endcase
  end

endmodule

// File: tb/tb_cutecar_level_pwm.sv
// Directed bench for cutecar_level_pwm with a scoreboard queue of expected values.
module tb_cutecar_level_pwm;
  import cutecar_pio_pkg::*;

  localparam int N_CH  = 7;
  localparam int CNT_W = 8;
  localparam int PRE_W = 16;

  logic            clk = 1'b0;
  logic            reset_n = 1'b0;
  logic [N_CH-1:0] out_port;

  cutecar_level_pwm_if bus();

  cutecar_level_pwm #(.N_CH(N_CH), .CNT_W(CNT_W), .PRE_W(PRE_W)) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .bus      (bus),
    .out_port (out_port)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int total = 0;
  int bad   = 0;
  logic [31:0] exp_q[$];

  // Reference model state
  int        c0;
  int        pre_m;
  int        per_m;
  int        dw_edge[$];
  int        dw_val[$];
  logic [6:0] m_data;
  logic [6:0] m_mode;

  task automatic expect_v(input logic [31:0] v);
    exp_q.push_back(v);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs);
    logic [31:0] e;
    total++;
    if (exp_q.size() == 0) begin
      bad++;
      $error("FAIL %s obs=%0h exp=<none queued>", tag, obs);
    end else begin
      e = exp_q.pop_front();
      assert (obs === e) else begin
        bad++;
        $error("FAIL %s obs=%0h exp=%0h", tag, obs, e);
      end
    end
  endtask

  // Called at a falling edge: the following rising edge is the write edge
  task automatic wr(input logic [3:0] a, input logic [31:0] d);
    bus.address    = a;
    bus.writedata  = d;
    bus.chipselect = 1'b1;
    bus.write_n    = 1'b0;
    @(negedge clk);
    bus.chipselect = 1'b0;
    bus.write_n    = 1'b1;
    bus.writedata  = '0;
  endtask

  task automatic rd(input logic [3:0] a, output logic [31:0] d);
    bus.address = a;
    #1;
    d = bus.readdata;
  endtask

  task automatic rd_chk(input string tag, input logic [3:0] a, input logic [31:0] e);
    logic [31:0] d;
    expect_v(e);
    rd(a, d);
    chk(tag, d);
  endtask

  function automatic int per_len();
    return (per_m + 1) * (pre_m + 1);
  endfunction

  // Counter value after the j-th rising edge since enable
  function automatic int m_cnt(input int j);
    return (j / (pre_m + 1)) % (per_m + 1);
  endfunction

  // Duty in force during period p: last write whose edge precedes the period start
  function automatic int m_duty(input int p);
    int v = 0;
    for (int i = 0; i < dw_edge.size(); i++)
      if (dw_edge[i] < p * per_len()) v = dw_val[i];
    return v;
  endfunction

  function automatic logic [6:0] m_out(input int j);
    logic pw;
    pw = (j > 0) && (m_cnt(j - 1) < m_duty((j - 1) / per_len()));
    return (m_data & ~m_mode) | {6'b0, pw & m_mode[0]};
  endfunction

  // Queue n cycles of expected COUNTER/out_port, then compare cycle by cycle
  task automatic run(input int n);
    int j0;
    logic [31:0] d;
    j0 = cyc - c0;
    for (int i = 0; i < n; i++) begin
      expect_v(32'(m_cnt(j0 + i)));
      expect_v(32'(m_out(j0 + i)));
    end
    for (int i = 0; i < n; i++) begin
      rd(ADDR_COUNTER, d);
      chk("counter", d);
      chk("pwm_out", 32'(out_port));
      @(negedge clk);
    end
  endtask

  // Run until the next write edge sits at offset t within the period
  task automatic align(input int t);
    for (int i = 0; i < per_len() && (((cyc - c0 + 1) % per_len()) != t); i++)
      run(1);
  endtask

  task automatic wr_duty(input int v);
    dw_edge.push_back(cyc - c0 + 1);
    dw_val.push_back(v);
    wr(ADDR_DUTY0, 32'(v));
  endtask

  task automatic enable();
    wr(ADDR_CONTROL, 32'h1);
    c0 = cyc;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [6:0] mo;
    bus.address = '0; bus.chipselect = 1'b0; bus.write_n = 1'b1; bus.writedata = '0;
    m_data = '0; m_mode = '0; pre_m = 0; per_m = 9; c0 = 0;

    repeat (3) @(negedge clk);
    expect_v(32'h0); chk("out_in_reset", 32'(out_port));
    reset_n = 1'b1;
    @(negedge clk);

    // All registers read 0 after reset
    for (int a = 0; a < 16; a++) begin
      rd_chk("rst_read", 4'(a), 32'h0);
      @(negedge clk);
    end
    expect_v(32'h0); chk("rst_out", 32'(out_port));

    // Direct write, visible right after the write edge
    wr(ADDR_DATA, 32'h55); m_data = 7'h55;
    expect_v(32'h55); chk("data_out", 32'(out_port));
    rd_chk("data_rd", ADDR_DATA, 32'h55);
    @(negedge clk);

    // Upper write bits ignored, set/clear, write-only holes
    wr(ADDR_DATA, 32'hFFFF_FF0F);
    rd_chk("data_trunc", ADDR_DATA, 32'h0F);
    @(negedge clk);
    wr(ADDR_OUTSET, 32'h30);
    rd_chk("outset", ADDR_DATA, 32'h3F);
    @(negedge clk);
    wr(ADDR_OUTCLEAR, 32'h03);
    rd_chk("outclear", ADDR_DATA, 32'h3C);
    expect_v(32'h3C); chk("setclr_out", 32'(out_port));
    rd_chk("rd_outset", ADDR_OUTSET, 32'h0);
    @(negedge clk);
    rd_chk("rd_outclear", ADDR_OUTCLEAR, 32'h0);
    wr(4'd15, 32'hAB);
    rd_chk("rd_oor_duty", 4'd15, 32'h0);
    @(negedge clk);

    // PWM setup on channel 0
    wr(ADDR_DATA, 32'h0); m_data = '0;
    wr(ADDR_MODE, 32'h1); m_mode = 7'h01;
    wr(ADDR_PRESCALE, 32'h0);
    wr(ADDR_PERIOD, 32'd9);
    wr(ADDR_DUTY0, 32'd3);
    rd_chk("period_rd", ADDR_PERIOD, 32'd9);
    rd_chk("duty0_rd", ADDR_DUTY0, 32'd3);
    rd_chk("mode_rd", ADDR_MODE, 32'h1);
    @(negedge clk);
    dw_edge.delete(); dw_val.delete();
    dw_edge.push_back(-1); dw_val.push_back(3);
    enable();
    rd_chk("control_rd", ADDR_CONTROL, 32'h1);
    @(negedge clk);
    c0 = c0 + 0;
    run(29);

    // Mid-period duty change, then one landing on the wrap edge
    align(4); wr_duty(7); run(25);
    align(0); wr_duty(5); run(25);

    // Duty extremes
    wr_duty(0);  run(25);
    wr_duty(12); run(25);

    // Clearing EN mid-period
    align(5);
    wr(ADDR_CONTROL, 32'h0);
    @(negedge clk);
    rd_chk("en_clr_counter", ADDR_COUNTER, 32'h0);
    expect_v(32'h0); chk("en_clr_out", 32'(out_port));
    rd_chk("en_clr_ctrl", ADDR_CONTROL, 32'h0);
    @(negedge clk);

    // Prescaled run: 50-cycle period, counter steps every 5 cycles
    wr(ADDR_PRESCALE, 32'd4); pre_m = 4;
    wr(ADDR_DUTY0, 32'd3);
    dw_edge.delete(); dw_val.delete();
    dw_edge.push_back(-1); dw_val.push_back(3);
    enable();
    run(110);
    wr(ADDR_DATA, 32'h40); m_data = 7'h40;
    run(5);

    // Asynchronous reset in the middle of a high pulse
    for (int i = 0; i < 60; i++) begin
      mo = m_out(cyc - c0);
      if (mo[0]) break;
      run(1);
    end
    expect_v(32'(m_out(cyc - c0))); chk("pre_rst_out", 32'(out_port));
    #2 reset_n = 1'b0;
    #1;
    expect_v(32'h0); chk("async_rst_out", 32'(out_port));
    @(negedge clk);
    reset_n = 1'b1;
    m_data = '0; m_mode = '0;
    @(negedge clk);
    rd_chk("post_rst_ctrl", ADDR_CONTROL, 32'h0);
    rd_chk("post_rst_data", ADDR_DATA, 32'h0);
    rd_chk("post_rst_mode", ADDR_MODE, 32'h0);
    @(negedge clk);
    rd_chk("post_rst_pre", ADDR_PRESCALE, 32'h0);
    rd_chk("post_rst_per", ADDR_PERIOD, 32'h0);
    rd_chk("post_rst_duty", ADDR_DUTY0, 32'h0);
    @(negedge clk);
    @(negedge clk);
    rd_chk("post_rst_cnt", ADDR_COUNTER, 32'h0);
    expect_v(32'h0); chk("post_rst_out", 32'(out_port));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
